// File: rtl/cpu_defs.sv
// ----------------------------------------------------------------------------
// cpu_defs
//   Definitions shared by the pipeline front end.
//   NOP_INST    : bubble presented to decode when no fetched entry is available
//                 (sll $0,$0,0 encodes as all zeros).
//   INST_W_DEF  : default instruction width.
//   PC_W_DEF    : default width of the pc+4 value carried with each instruction.
// ----------------------------------------------------------------------------
package cpu_defs;

   localparam int          INST_W_DEF = 32;
   localparam int          PC_W_DEF   = 32;
   localparam logic [31:0] NOP_INST   = 32'h0000_0000;

endpackage : cpu_defs

// File: rtl/fq_storage.sv
// ----------------------------------------------------------------------------
// fq_storage
//   DEPTH x WIDTH register array backing the fetch queue.
//   One synchronous write port and one asynchronous (combinational) read
//   port, so the queue head is visible in the same cycle its pointer moves.
// Ports
//   clk_i    : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
// ----------------------------------------------------------------------------
module fq_storage #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the array has no reset; occupancy is tracked by the control logic,
   // so stale contents are never presented and clearing them would only cost
   // a reset fan-out to every storage flop.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : fq_storage

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch queue between IF and ID. Buffers {pc+4, instruction}
//   pairs so IF can run ahead while ID is stalled by a hazard. The head is
//   shown directly from storage (show-ahead, no output register). A
//   branch/jump flush discards every entry. An empty queue presents a NOP
//   bubble to decode.
// Parameters
//   INST_W  : instruction width
//   PC_W    : pc+4 width
//   DEPTH   : number of entries, power of two, >= 2
//   BYPASS  : 1 = push into an empty queue with a same-cycle pop passes the
//             fetched pair straight through to decode
//   PTR_W   : derived pointer width
// Ports
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous reset, active low
//   push_i   in   IF presents a valid fetch
//   inst_i   in   fetched instruction
//   pc_i     in   pc+4 of the fetched instruction
//   full_o   out  queue holds DEPTH entries; IF must stall its PC
//   pop_i    in   ID consumes the head (no hazard stall)
//   flush_i  in   branch taken / jump: discard all entries
//   valid_o  out  head entry valid
//   inst_o   out  head instruction, NOP_INST when !valid_o
//   pc_o     out  head pc+4, zero when !valid_o
//   count_o  out  occupancy, 0..DEPTH
//   empty_o  out  occupancy is zero
//   drop_o   out  one-cycle pulse the cycle after a refused push
// ----------------------------------------------------------------------------
module fetch_queue
   import cpu_defs::*;
#(
   parameter  int INST_W = INST_W_DEF,
   parameter  int PC_W   = PC_W_DEF,
   parameter  int DEPTH  = 4,
   parameter  int BYPASS = 0,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [INST_W-1:0] inst_i,
   input  logic [PC_W-1:0]   pc_i,
   output logic              full_o,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic              valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [PC_W-1:0]   pc_o,
   output logic [PTR_W:0]    count_o,
   output logic              empty_o,
   output logic              drop_o
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             drop_q,   drop_d;

   logic             full;
   logic             empty;
   logic             bypass_hit;
   logic             pop_eff;
   logic             push_eff;
   logic             store_push;
   logic             store_pop;

   logic [INST_W+PC_W-1:0] head_data;
   logic [INST_W-1:0]      head_inst;
   logic [PC_W-1:0]        head_pc;

   // ------------------------------------------------------------------
   // Status decode, from registered occupancy only
   // ------------------------------------------------------------------
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // Pass-through: the fetched pair is consumed in the cycle it arrives and
   // never touches storage, pointers or occupancy.
   assign bypass_hit = (BYPASS != 0) && empty && push_i && pop_i && !flush_i;

   assign valid_o  = !empty || bypass_hit;
   assign pop_eff  = pop_i && valid_o;
   // A pop in the same cycle frees the slot, so a full queue still accepts.
   assign push_eff = push_i && (!full || pop_eff) && !flush_i;

   assign store_push = push_eff && !bypass_hit;
   assign store_pop  = pop_eff  && !bypass_hit;

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   fq_storage #(
      .DEPTH (DEPTH),
      .WIDTH (INST_W + PC_W),
      .PTR_W (PTR_W)
   ) u_storage (
      .clk_i   (clk_i),
      .we_i    (store_push),
      .waddr_i (wr_ptr_q),
      .wdata_i ({pc_i, inst_i}),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_data)
   );

   assign {head_pc, head_inst} = head_data;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // NOTE: every signal driven here gets a default before any branch, so no
   // path leaves it unassigned and no latch can be inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = push_i && full && !pop_eff && !flush_i;

      if (flush_i) begin
         // Flush outranks push and pop: the queue empties in place by
         // catching the read pointer up to the write pointer.
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (store_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (store_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({store_push, store_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   // NOTE: state updates use non-blocking assignments so every register
   // samples the values of the previous cycle regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      inst_o = INST_W'(NOP_INST);
      pc_o   = '0;
      if (bypass_hit) begin
         inst_o = inst_i;
         pc_o   = pc_i;
      end else if (!empty) begin
         inst_o = head_inst;
         pc_o   = head_pc;
      end
   end

   assign full_o  = full;
   assign empty_o = empty;
   assign count_o = count_q;
   assign drop_o  = drop_q;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//   Scoreboard bench for fetch_queue. The main instance (BYPASS=0, DEPTH=4)
//   is driven by directed and random stimulus; the stimulus side pushes each
//   accepted fetch into an expected queue, and a monitor on the falling edge
//   compares the DUT head/status against that queue and retires entries as
//   decode consumes them. A second instance (BYPASS=1) covers pass-through.
// ----------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   logic        clk;
   logic        rst_i;

   // main DUT (BYPASS = 0)
   logic        push_i, pop_i, flush_i;
   logic [31:0] inst_i, pc_i;
   logic        full_o, valid_o, empty_o, drop_o;
   logic [31:0] inst_o, pc_o;
   logic [2:0]  count_o;

   // pass-through DUT (BYPASS = 1)
   logic        b_push, b_pop, b_flush;
   logic [31:0] b_inst_i, b_pc_i;
   logic        b_full, b_valid, b_empty, b_drop;
   logic [31:0] b_inst_o, b_pc_o;
   logic [2:0]  b_count;

   entry_t      exp_q[$];
   logic        exp_drop;
   bit          mon_en;

   int          n_checks;
   int          n_fail;

   fetch_queue #(.INST_W(32), .PC_W(32), .DEPTH(DEPTH), .BYPASS(0)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .push_i  (push_i),
      .inst_i  (inst_i),
      .pc_i    (pc_i),
      .full_o  (full_o),
      .pop_i   (pop_i),
      .flush_i (flush_i),
      .valid_o (valid_o),
      .inst_o  (inst_o),
      .pc_o    (pc_o),
      .count_o (count_o),
      .empty_o (empty_o),
      .drop_o  (drop_o)
   );

   fetch_queue #(.INST_W(32), .PC_W(32), .DEPTH(DEPTH), .BYPASS(1)) dut_b (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .push_i  (b_push),
      .inst_i  (b_inst_i),
      .pc_i    (b_pc_i),
      .full_o  (b_full),
      .pop_i   (b_pop),
      .flush_i (b_flush),
      .valid_o (b_valid),
      .inst_o  (b_inst_o),
      .pc_o    (b_pc_o),
      .count_o (b_count),
      .empty_o (b_empty),
      .drop_o  (b_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Monitor: compare status and head against the expected queue, retire
   // the head when decode consumes it.
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      if (mon_en) begin
         entry_t head;
         check("count", 64'(count_o), 64'(exp_q.size()));
         check("empty", 64'(empty_o), 64'(exp_q.size() == 0));
         check("full",  64'(full_o),  64'(exp_q.size() == DEPTH));
         check("valid", 64'(valid_o), 64'(exp_q.size() != 0));
         check("drop",  64'(drop_o),  64'(exp_drop));
         if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("head_inst", 64'(inst_o), 64'(head.inst));
            check("head_pc",   64'(pc_o),   64'(head.pc));
            if (pop_i === 1'b1) begin
               void'(exp_q.pop_front());
            end
         end else begin
            check("bubble_inst", 64'(inst_o), 64'h0);
            check("bubble_pc",   64'(pc_o),   64'h0);
         end
      end
   end

   // ------------------------------------------------------------------
   // One cycle of stimulus on the main DUT. Called at posedge+1; returns at
   // the next posedge+1 with the expected queue updated for that edge.
   // ------------------------------------------------------------------
   task automatic step(input bit push, input logic [31:0] inst, input logic [31:0] pc,
                       input bit pop, input bit flush);
      int sz;
      bit pop_e, push_e, drop_e;
      push_i  = push;
      inst_i  = inst;
      pc_i    = pc;
      pop_i   = pop;
      flush_i = flush;
      sz      = exp_q.size();
      pop_e   = pop && (sz > 0);
      push_e  = push && ((sz < DEPTH) || pop_e) && !flush;
      drop_e  = push && (sz == DEPTH) && !pop_e && !flush;
      @(posedge clk);
      if (flush) begin
         exp_q.delete();
      end else if (push_e) begin
         exp_q.push_back('{inst: inst, pc: pc});
      end
      exp_drop = drop_e;
      #1;
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      mon_en   = 1'b0;
      exp_drop = 1'b0;
      rst_i    = 1'b1;
      push_i   = 1'b0; pop_i = 1'b0; flush_i = 1'b0; inst_i = '0; pc_i = '0;
      b_push   = 1'b0; b_pop = 1'b0; b_flush = 1'b0; b_inst_i = '0; b_pc_i = '0;

      // Reset held for three cycles; the monitor checks reset values meanwhile.
      #2 rst_i = 1'b0;
      mon_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b1;

      // Fill to full, one refused push, drain in order.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 32'h2008_0001 + 32'(i), 32'(4 * (i + 1)), 1'b0, 1'b0);
      end
      step(1'b1, 32'h2008_0005, 32'd20, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      idle();

      // Full with simultaneous push and pop.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 32'h3000_00A0 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      end
      step(1'b1, 32'h3000_00BB, 32'h200, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      idle();

      // Flush at count 3 with a simultaneous push and pop.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h4000_0010 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      end
      step(1'b1, 32'h4000_00FF, 32'h3F0, 1'b1, 1'b1);
      idle();

      // Flush of a full queue with a push: no drop pulse.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 32'h5000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b0);
      end
      step(1'b1, 32'h5000_00FF, 32'h4F0, 1'b0, 1'b1);
      idle();

      // Wrap: interleaved push/pop across several pointer wraps.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'h6000_0000 + 32'(i), 32'h500 + 32'(4 * i), (i % 3) != 0, 1'b0);
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end

      // Reset in the middle of operation.
      step(1'b1, 32'h7000_0001, 32'h600, 1'b0, 1'b0);
      step(1'b1, 32'h7000_0002, 32'h604, 1'b0, 1'b0);
      push_i = 1'b0;
      #2;
      rst_i = 1'b0;
      exp_q.delete();
      exp_drop = 1'b0;
      @(posedge clk);
      #1 rst_i = 1'b1;
      idle();

      // Randomised traffic.
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 9) < 6, $urandom(), $urandom(),
              $urandom_range(0, 9) < 5, $urandom_range(0, 15) == 0);
      end
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      // Push with pop into an empty queue, no pass-through: bubble this
      // cycle, the entry shows next cycle.
      step(1'b1, 32'h8C09_0000, 32'h700, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      idle();

      // Pass-through instance (main DUT idles with zero inputs).
      b_push = 1'b1; b_inst_i = 32'h8C09_0000; b_pc_i = 32'h44; b_pop = 1'b1;
      @(negedge clk);
      check("byp_valid", 64'(b_valid),  64'h1);
      check("byp_inst",  64'(b_inst_o), 64'h8C09_0000);
      check("byp_pc",    64'(b_pc_o),   64'h44);
      check("byp_count", 64'(b_count),  64'h0);
      @(posedge clk); #1;
      b_push = 1'b0; b_pop = 1'b0;
      @(negedge clk);
      check("byp_after_count", 64'(b_count),  64'h0);
      check("byp_after_valid", 64'(b_valid),  64'h0);
      check("byp_after_inst",  64'(b_inst_o), 64'h0);
      @(posedge clk); #1;
      b_push = 1'b1; b_inst_i = 32'h8C0A_0001; b_pc_i = 32'h48; b_pop = 1'b0;
      @(negedge clk);
      check("byp_nopop_valid", 64'(b_valid),  64'h0);
      check("byp_nopop_inst",  64'(b_inst_o), 64'h0);
      @(posedge clk); #1;
      b_push = 1'b1; b_inst_i = 32'h8C0B_0002; b_pc_i = 32'h4C; b_pop = 1'b1;
      @(negedge clk);
      check("byp_busy_inst",  64'(b_inst_o), 64'h8C0A_0001);
      check("byp_busy_count", 64'(b_count),  64'h1);
      @(posedge clk); #1;
      b_push = 1'b0; b_pop = 1'b0;
      @(negedge clk);
      check("byp_next_inst",  64'(b_inst_o), 64'h8C0B_0002);
      check("byp_next_pc",    64'(b_pc_o),   64'h4C);
      check("byp_next_count", 64'(b_count),  64'h1);
      check("byp_drop",       64'(b_drop),   64'h0);

      @(posedge clk); #1;
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fetch_queue
